conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning signed pixel width.
REQ-002 The module SHALL have parameter IMG_W, default 32, meaning pixels per row (>=3).
REQ-003 The module SHALL have parameter IMG_H, default 32, meaning rows per frame (>=3).
REQ-004 The module SHALL have port clk, input, 1 bit, the clock.
REQ-005 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The module SHALL have port in_data, input, DATA_W bits, the signed raster-order pixel.
REQ-007 The module SHALL have port in_valid, input, 1 bit, which qualifies in_data; there is no backpressure.
REQ-008 The module SHALL have port in_sof, input, 1 bit, start-of-frame; it is sampled only with in_valid.
REQ-009 The module SHALL have port window, output, 9*DATA_W bits, the 3x3 window packed for the depthwise MAC.
REQ-010 The module SHALL have port window_valid, output, 1 bit, a one-cycle strobe per window.
REQ-011 The module SHALL have port frame_done, output, 1 bit, a one-cycle strobe with the last window of a frame.

Function
REQ-012 Each accepted pixel (in_valid=1) SHALL be written to the line buffers and the 3x3 shift window; with in_valid=0, all state SHALL hold.
REQ-013 Window slot i = 3*r + c SHALL occupy window[DATA_W*i +: DATA_W]: r=0 is the oldest row (top), c=0 is the leftmost column, and slot 8 is the newest pixel.
REQ-014 Two line buffers of IMG_W x DATA_W SHALL hold rows y-1 and y-2, using a read-before-write per column.
REQ-015 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance per accepted pixel; col SHALL wrap to 0 and increment row; at (IMG_W-1, IMG_H-1), both SHALL wrap to 0.
REQ-016 The FSM SHALL have states FILL and RUN: FILL applies while row<2, RUN applies while row>=2, and FILL->RUN occurs on acceptance of pixel (IMG_W-1, 1).
REQ-017 RUN->FILL SHALL occur on acceptance of the last pixel of a frame, or on any accepted pixel with in_sof=1.
REQ-018 An accepted pixel with in_sof=1 SHALL be treated as (0,0) regardless of the counters (resync); it SHALL emit no window and SHALL set col=1, row=0.
REQ-019 window_valid SHALL assert exactly one cycle after acceptance of a pixel at row>=2 and col>=2 (valid convolution, no padding), giving (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-020 window SHALL be registered and SHALL change only in the cycle window_valid asserts; otherwise it SHALL hold its last value.
REQ-021 frame_done SHALL assert in the same cycle as the window_valid for pixel (IMG_W-1, IMG_H-1).
REQ-022 Windows SHALL never straddle rows: columns 0 and 1 of each row SHALL refill the shift window without emitting.
REQ-023 Pixel values SHALL pass through unmodified, with no arithmetic and no sign change.
REQ-024 Throughput SHALL be one pixel per cycle, sustained indefinitely, with arbitrary in_valid gaps allowed.

Reset
REQ-025 On reset, window_valid=0, frame_done=0, window=0, col=0, row=0, and state=FILL.
REQ-026 Line buffer contents SHALL NOT need reset, because FILL suppresses all output until both rows are rewritten.
REQ-027 Reset mid-frame SHALL discard the partial frame; the next accepted pixel SHALL be treated as (0,0).

Structure
REQ-028 DATA_W default, K=3, and the FSM state encodings SHALL reside in the shared cnn_pkg package.
REQ-029 The line buffer SHALL be one sub-module, line_buffer, instantiated twice: a single-port IMG_W x DATA_W memory with synchronous read-before-write, inferred as BRAM/LUTRAM.
REQ-030 Counter widths SHALL be $clog2(IMG_W) and $clog2(IMG_H).

Verification
REQ-031 A 5x5 frame with pixel = 5*row+col, continuous -> 9 windows; the first, one cycle after pixel (2,2), SHALL equal slots {0,1,2,5,6,7,10,11,12}; the last SHALL equal {12,13,14,17,18,19,22,23,24} with frame_done=1.
REQ-032 The same frame with random in_valid gaps (about 50% duty) -> identical window sequence, each window_valid exactly one cycle after its completing pixel.
REQ-033 Two back-to-back frames -> 18 windows, and the second frame's first window SHALL contain only second-frame data.
REQ-034 in_sof asserted at pixel (3,2) of frame 1 -> no window for that pixel, the counters resync, and a full 9-window frame follows.
REQ-035 Reset asserted after 12 pixels, then a fresh frame -> no outputs during or after reset until pixel (2,2) of the new frame, and the window contents are correct.
REQ-036 Pixels of -128 and 127 in all slots -> window bytes reproduced bit-exact, with no sign corruption.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN front-end definitions: default pixel width, kernel size, window FSM states.
package cnn_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned K          = 3;
  localparam int unsigned WIN_SLOTS  = K * K;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage; the old word is visible on rdata_c before the write lands.
module line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: the column's previous row is consumed in the same cycle it is overwritten.
  assign rdata_c = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to 3x3 sliding windows (valid convolution, no padding).
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          in_sof,
  output logic [WIN_SLOTS*DATA_W-1:0]   window,
  output logic                          window_valid,
  output logic                          frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  win_state_e                   state;
  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic [K-1:0][DATA_W-1:0]     col_m2;
  logic [K-1:0][DATA_W-1:0]     col_m1;

  logic [COL_W-1:0]             addr_c;
  logic [DATA_W-1:0]            lb0_rd_c;
  logic [DATA_W-1:0]            lb1_rd_c;
  logic [K-1:0][DATA_W-1:0]     new_col_c;
  logic [WIN_SLOTS*DATA_W-1:0]  win_c;
  logic                         last_col_c;
  logic                         last_row_c;
  logic                         emit_c;

  // A start-of-frame pixel always lands in column 0, whatever the counters say.
  assign addr_c     = in_sof ? '0 : col;
  assign last_col_c = (col == COL_W'(IMG_W - 1));
  assign last_row_c = (row == ROW_W'(IMG_H - 1));
  assign emit_c     = in_valid && !in_sof && (state == ST_RUN) && (col >= COL_W'(2));

  // lb0 holds row y-1; its displaced word cascades into lb1, which holds row y-2.
  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb0 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (addr_c),
    .wdata   (in_data),
    .rdata_c (lb0_rd_c)
  );

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb1 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (addr_c),
    .wdata   (lb0_rd_c),
    .rdata_c (lb1_rd_c)
  );

  // Incoming column, top (oldest row) to bottom (current pixel).
  always_comb begin
    new_col_c    = '0;
    new_col_c[0] = lb1_rd_c;
    new_col_c[1] = lb0_rd_c;
    new_col_c[2] = in_data;
  end

  // Slot 3*r+c: two stored columns on the left, the incoming column on the right.
  always_comb begin
    win_c = '0;
    for (int r = 0; r < int'(K); r++) begin
      win_c[(K*r + 0)*DATA_W +: DATA_W] = col_m2[r];
      win_c[(K*r + 1)*DATA_W +: DATA_W] = col_m1[r];
      win_c[(K*r + 2)*DATA_W +: DATA_W] = new_col_c[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_FILL;
      col          <= '0;
      row          <= '0;
      col_m2       <= '0;
      col_m1       <= '0;
      window       <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= emit_c;
      frame_done   <= emit_c && last_col_c && last_row_c;
      if (emit_c) window <= win_c;

      if (in_valid) begin
        col_m2 <= col_m1;
        col_m1 <= new_col_c;

        if (in_sof) begin
          // Resync: this pixel was (0,0), so the next one is (1,0).
          col   <= COL_W'(1);
          row   <= '0;
          state <= ST_FILL;
        end else begin
          if (last_col_c) begin
            col <= '0;
            row <= last_row_c ? '0 : row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end

          case (state)
            ST_FILL: if (last_col_c && (row == ROW_W'(1))) state <= ST_RUN;
            ST_RUN:  if (last_col_c && last_row_c)         state <= ST_FILL;
            default:                                       state <= ST_FILL;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x5 frame with an independent full-frame model.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int WB = 9 * DW;

  typedef struct {
    logic [WB-1:0] win;
    logic          fd;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [WB-1:0] window;
  logic          window_valid;
  logic          frame_done;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_win = 0;

  exp_t          exp_q[$];
  logic [WB-1:0] last_exp = '0;
  logic [DW-1:0] img [H][W];
  int            m_col = 0;
  int            m_row = 0;

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .window       (window),
    .window_valid (window_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one accepted pixel and predict what it should produce.
  task automatic send(input logic [DW-1:0] d, input logic sof);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    if (sof) begin
      img[0][0] = d;
      m_col = 1;
      m_row = 0;
    end else begin
      img[m_row][m_col] = d;
      if (m_row >= 2 && m_col >= 2) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[DW*(3*r+c) +: DW] = img[m_row-2+r][m_col-2+c];
        e.fd  = (m_row == H-1) && (m_col == W-1);
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = DW'($urandom);
    end
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int k = 0; k < W*H; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      send(DW'(base + k), 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_col = 0;
    m_row = 0;
    exp_q.delete();
  endtask

  // Output monitor: pop on every strobe, otherwise the window must hold and frame_done stay low.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (window_valid) begin
      n_win++;
      if (exp_q.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("window", window, e.win);
        chk("frame_done", WB'(frame_done), WB'(e.fd));
        chk("latency", WB'(cyc), WB'(e.cyc));
        last_exp = e.win;
      end
    end else begin
      chk("fd_idle", WB'(frame_done), 0);
      chk("hold", window, last_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    logic [WB-1:0] ref_win;

    repeat (3) @(negedge clk);
    chk("rst_valid", WB'(window_valid), 0);
    chk("rst_fd", WB'(frame_done), 0);
    chk("rst_window", window, 0);
    reset = 1'b0;

    // Continuous frame, pixel = 5*row+col, with hand-built first and last windows.
    w0 = n_win;
    send_frame(0, 1'b0);
    idle(3);
    chk("t1_count", WB'(n_win - w0), 9);
    ref_win = '0;
    for (int s = 0; s < 9; s++) ref_win[DW*s +: DW] = DW'(12 + 5*(s/3) + (s%3));
    chk("t1_last_window", last_exp, ref_win);

    // Same frame with random gaps.
    w0 = n_win;
    send_frame(0, 1'b1);
    idle(3);
    chk("t2_count", WB'(n_win - w0), 9);

    // Two back-to-back frames.
    w0 = n_win;
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    idle(3);
    chk("t3_count", WB'(n_win - w0), 18);

    // start-of-frame at (3,2): one window from the old frame, then a full new frame.
    w0 = n_win;
    for (int k = 0; k < 13; k++) send(DW'(k), 1'b0);
    send(DW'(200), 1'b1);
    for (int k = 1; k < W*H; k++) send(DW'(200 + k), 1'b0);
    idle(3);
    chk("t4_count", WB'(n_win - w0), 10);

    // Reset after 12 pixels, then a fresh frame.
    w0 = n_win;
    for (int k = 0; k < 12; k++) send(DW'(50 + k), 1'b0);
    do_reset();
    chk("t5_after_reset", WB'(n_win - w0), 0);
    send_frame(150, 1'b1);
    idle(3);
    chk("t5_count", WB'(n_win - w0), 9);

    // Extreme signed values in a checkerboard and its inverse.
    w0 = n_win;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < W*H; k++)
        send((((k / W) + (k % W) + f) % 2 == 1) ? 8'h7F : 8'h80, 1'b0);
    idle(3);
    chk("t6_count", WB'(n_win - w0), 18);

    chk("queue_empty", WB'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
